// File: rtl/prng_xoshiro128p_pkg.sv
// Shared types and jump polynomials for the xoshiro128+ jump engine.
package prng_xoshiro128p_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_WORDS = 4;
    localparam int unsigned STATE_W   = WORD_W * NUM_WORDS;
    localparam int unsigned IDX_W     = 7;
    localparam int unsigned LAST_IDX  = 127;

    // Word k of a state lives at index k, so the flattened bit number is 32*word + bit.
    typedef logic [NUM_WORDS-1:0][WORD_W-1:0] xo_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_LOAD  = 2'd2
    } jump_state_e;

    localparam xo_state_t JUMP_C = {
        32'h77f2db5b, 32'h6fa035c3, 32'hf542d2d3, 32'h8764000b
    };

    localparam xo_state_t LONG_JUMP_C = {
        32'h1c580662, 32'hccf5a0ef, 32'h0b6f099f, 32'hb523952e
    };

    // Polynomial bit k: word k[6:5], bit k[4:0], which is flat bit k of the packed constant.
    function automatic logic jump_bit(input logic long_sel, input logic [IDX_W-1:0] idx);
        logic [STATE_W-1:0] flat;
        flat = long_sel ? STATE_W'(LONG_JUMP_C) : STATE_W'(JUMP_C);
        return flat[idx];
    endfunction

endpackage

// File: rtl/prng_xoshiro128p_jump.sv
// Jump/long-jump engine: steps an external xoshiro128+ generator 128 times while
// accumulating selected states, then loads the accumulated state back as a seed.
module prng_xoshiro128p_jump
    import prng_xoshiro128p_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic        i_long,
    input  logic        i_cg,
    input  logic [31:0] i_s0,
    input  logic [31:0] i_s1,
    input  logic [31:0] i_s2,
    input  logic [31:0] i_s3,
    output logic        o_cg,
    output logic        o_seedValid,
    output logic [31:0] o_seedS0,
    output logic [31:0] o_seedS1,
    output logic [31:0] o_seedS2,
    output logic [31:0] o_seedS3,
    output logic        o_busy,
    output logic        o_done
);

    jump_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    xo_state_t        acc_q, acc_d;
    logic             long_q, long_d;
    logic             done_q, done_d;
    xo_state_t        gen_s;

    assign gen_s = {i_s3, i_s2, i_s1, i_s0};

    // Next-state, accumulator update and generator-control decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        long_d      = long_q;
        done_d      = 1'b0;
        o_cg        = i_cg;
        o_busy      = 1'b0;
        o_seedValid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_ACCUM;
                    long_d  = i_long;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_ACCUM: begin
                o_cg   = 1'b1;
                o_busy = 1'b1;
                if (jump_bit(long_q, idx_q)) begin
                    acc_d = acc_q ^ gen_s;
                end
                idx_d = IDX_W'(idx_q + IDX_W'(1));
                if (idx_q == IDX_W'(LAST_IDX)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_cg        = 1'b1;
                o_busy      = 1'b1;
                o_seedValid = 1'b1;
                done_d      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            long_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            long_q  <= long_d;
            done_q  <= done_d;
        end
    end

    assign o_done   = done_q;
    assign o_seedS0 = acc_q[0];
    assign o_seedS1 = acc_q[1];
    assign o_seedS2 = acc_q[2];
    assign o_seedS3 = acc_q[3];

endmodule

// File: tb/tb_prng_xoshiro128p_jump.sv
// Bench for the jump engine: a behavioural xoshiro128+ generator closes the loop,
// expected seeds come from a C-style jump()/long_jump() model.
module tb_prng_xoshiro128p_jump;

    typedef logic [3:0][31:0] st_t;

    localparam st_t J_TB  = {32'h77f2db5b, 32'h6fa035c3, 32'hf542d2d3, 32'h8764000b};
    localparam st_t LJ_TB = {32'h1c580662, 32'hccf5a0ef, 32'h0b6f099f, 32'hb523952e};

    logic        i_clk   = 1'b0;
    logic        i_rstn  = 1'b0;
    logic        i_start = 1'b0;
    logic        i_long  = 1'b0;
    logic        i_cg    = 1'b0;
    logic        o_cg, o_seedValid, o_busy, o_done;
    logic [31:0] o_seedS0, o_seedS1, o_seedS2, o_seedS3;

    st_t  gen     = '0;
    st_t  tb_seed = '0;
    logic tb_load = 1'b0;

    int   cyc        = 0;
    int   start_cyc  = -1;
    int   prev_start = -1;
    bit   mon_en     = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    st_t  exp_q[$];

    logic busy_e, sv_e, done_e, cg_e;

    always #5 i_clk = ~i_clk;

    prng_xoshiro128p_jump dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_start     (i_start),
        .i_long      (i_long),
        .i_cg        (i_cg),
        .i_s0        (gen[0]),
        .i_s1        (gen[1]),
        .i_s2        (gen[2]),
        .i_s3        (gen[3]),
        .o_cg        (o_cg),
        .o_seedValid (o_seedValid),
        .o_seedS0    (o_seedS0),
        .o_seedS1    (o_seedS1),
        .o_seedS2    (o_seedS2),
        .o_seedS3    (o_seedS3),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    // xoshiro128+ next(): state update only.
    function automatic st_t xnext(input st_t s);
        logic [31:0] t;
        t    = s[1] << 9;
        s[2] = s[2] ^ s[0];
        s[3] = s[3] ^ s[1];
        s[1] = s[1] ^ s[2];
        s[0] = s[0] ^ s[3];
        s[2] = s[2] ^ t;
        s[3] = {s[3][20:0], s[3][31:21]};
        return s;
    endfunction

    // Reference jump()/long_jump() exactly as the C code loops over constant words.
    function automatic st_t jump_ref(input st_t s, input bit lng);
        st_t acc;
        st_t c;
        acc = '0;
        c   = lng ? LJ_TB : J_TB;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 32; b++) begin
                if (c[i][b]) acc = acc ^ s;
                s = xnext(s);
            end
        end
        return acc;
    endfunction

    // Behavioural generator sitting next to the engine.
    always @(posedge i_clk) begin
        if (tb_load)          gen <= tb_seed;
        else if (o_seedValid) gen <= {o_seedS3, o_seedS2, o_seedS1, o_seedS0};
        else if (o_cg)        gen <= xnext(gen);
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit in_win(input int s, input int lo, input int hi);
        return (s >= 0) && (cyc >= s + lo) && (cyc <= s + hi);
    endfunction

    // Monitor: per-cycle control checks and scoreboard pop on every seed load.
    always @(negedge i_clk) begin
        if (mon_en) begin
            busy_e = in_win(start_cyc, 1, 129)   || in_win(prev_start, 1, 129);
            sv_e   = in_win(start_cyc, 129, 129) || in_win(prev_start, 129, 129);
            done_e = in_win(start_cyc, 130, 130) || in_win(prev_start, 130, 130);
            cg_e   = busy_e ? 1'b1 : i_cg;
            chk("o_busy",      128'(o_busy),      128'(busy_e));
            chk("o_seedValid", 128'(o_seedValid), 128'(sv_e));
            chk("o_done",      128'(o_done),      128'(done_e));
            chk("o_cg",        128'(o_cg),        128'(cg_e));
            if (o_seedValid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_seed", 128'(1), 128'(0));
                end else begin
                    chk("seed", {o_seedS3, o_seedS2, o_seedS1, o_seedS0}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_seed(input st_t s);
        tb_load = 1'b1;
        tb_seed = s;
        i_cg    = 1'b0;
        step();
        tb_load = 1'b0;
    endtask

    // Advance to a target cycle, optionally with random i_cg and ignored i_start noise.
    task automatic run_to(input int target, input bit noise);
        for (int i = 0; i < 1000 && cyc < target; i++) begin
            if (noise) begin
                i_cg    = 1'($urandom);
                i_start = ($urandom_range(0, 7) == 0);
                i_long  = 1'($urandom);
            end
            step();
        end
        i_start = 1'b0;
        i_cg    = 1'b0;
        chk("cycle_reach", 128'(cyc), 128'(target));
    endtask

    // One full jump from the current cycle; optional extra start pulses at N+5 and N+60.
    task automatic jump_once(input bit lng, input bit noise, input bit poke);
        st_t e;
        int  n;
        e = jump_ref(gen, lng);
        exp_q.push_back(e);
        n          = cyc;
        prev_start = start_cyc;
        start_cyc  = n;
        i_start    = 1'b1;
        i_long     = lng;
        i_cg       = 1'b0;
        step();
        i_start = 1'b0;
        if (poke) begin
            run_to(n + 5, 1'b0);
            i_start = 1'b1; i_long = ~lng;
            step();
            i_start = 1'b0;
            run_to(n + 60, 1'b0);
            i_start = 1'b1;
            step();
            i_start = 1'b0;
        end
        run_to(n + 130, noise);
        chk("gen_after_jump", gen, e);
    endtask

    initial begin
        st_t s;
        st_t e;
        int  n;

        i_rstn = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        step();
        i_rstn = 1'b1;
        chk("reset_seed", {o_seedS3, o_seedS2, o_seedS1, o_seedS0}, 128'(0));

        // i_cg passes through while idle
        i_cg = 1'b1; step();
        i_cg = 1'b0; step();
        i_cg = 1'b1; step();
        i_cg = 1'b0; step();

        // Seed {1,2,3,4}: jump, then long jump, i_cg toggling during busy
        load_seed({32'd4, 32'd3, 32'd2, 32'd1});
        jump_once(1'b0, 1'b1, 1'b0);
        load_seed({32'd4, 32'd3, 32'd2, 32'd1});
        jump_once(1'b1, 1'b1, 1'b0);

        // All-zero state gives an all-zero seed
        load_seed('0);
        jump_once(1'b0, 1'b0, 1'b0);

        // Starts while busy are ignored; start in the done cycle restarts
        load_seed({32'h0badf00d, 32'h12345678, 32'hdeadbeef, 32'hcafef00d});
        jump_once(1'b0, 1'b0, 1'b1);
        jump_once(1'b1, 1'b0, 1'b0);

        // Reset at N+64 aborts with no seed load and 64 generator steps taken
        s = {$urandom, $urandom, $urandom, $urandom};
        load_seed(s);
        n          = cyc;
        prev_start = -1;
        start_cyc  = n;
        i_start    = 1'b1;
        i_long     = 1'b0;
        step();
        i_start = 1'b0;
        run_to(n + 64, 1'b0);
        i_rstn = 1'b0;
        step();
        start_cyc  = -1;
        prev_start = -1;
        step();
        i_rstn = 1'b1;
        e = s;
        for (int i = 0; i < 64; i++) e = xnext(e);
        chk("gen_after_abort", gen, e);
        run_to(cyc + 140, 1'b0);
        chk("gen_idle_hold", gen, e);

        // Randomised jumps, some back-to-back from the done cycle
        for (int r = 0; r < 6; r++) begin
            load_seed({$urandom, $urandom, $urandom, $urandom});
            jump_once(1'($urandom), 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) jump_once(1'($urandom), 1'b1, 1'b0);
            for (int i = 0; i < 4; i++) begin
                i_cg = 1'($urandom);
                step();
            end
            i_cg = 1'b0;
        end

        step();
        step();
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

endmodule
